// File: rtl/icache_ctrl_nway.sv
// N-way set-associative instruction cache controller with tree-PLRU
// replacement and whole-cache flush. Tags, valids, PLRU bits and line data
// are all held in flops.
// Optional feature: define ICACHE_PERF_CNT_EN to add the saturating
// perf_hit_cnt / perf_miss_cnt outputs.
module icache_ctrl_nway #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int SETS       = 16,
    parameter int WAYS       = 4,
    parameter int FETCH_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       ufp_addr,
    input  logic [FETCH_W/8-1:0]    ufp_rmask,
    output logic                    ufp_ready,
    output logic [FETCH_W-1:0]      ufp_rdata,
    output logic                    ufp_resp,
    input  logic                    flush,
    output logic [ADDR_W-1:0]       dfp_addr,
    output logic                    dfp_read,
    input  logic [LINE_BYTES*8-1:0] dfp_rdata,
    input  logic                    dfp_resp
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]             perf_hit_cnt,
    output logic [31:0]             perf_miss_cnt
`endif
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int SET_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - SET_W;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int PL_W   = WAYS - 1;
    localparam int BYTE_W = $clog2(FETCH_W / 8);
    localparam int WPL    = LINE_W / FETCH_W;
    localparam int WIDX_W = (WPL > 1) ? $clog2(WPL) : 1;

    typedef enum logic [1:0] {PASS_THRU, ALLOCATE, ALLOCATE_STALL} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_stg_vld;
    logic [WIDX_W-1:0]   r_stg_widx;
    logic [SET_W-1:0]    r_stg_set;
    logic [TAG_W-1:0]    r_stg_tag;
    logic                r_flush_pend;
    logic [WAYS-1:0]     r_valid [SETS];
    logic [PL_W-1:0]     r_plru  [SETS];
    logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
    logic [LINE_W-1:0]   r_data  [SETS][WAYS];

    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way;
    logic [WAY_W-1:0]    w_vict;
    logic [LINE_W-1:0]   w_line_sh;
    logic                w_flush_now;
    logic                w_accept;
    logic                w_fill;

    // Walk the tree toward the least-recently-used side; a set bit means "go right".
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] bits);
        int              node;
        logic [PL_W-1:0] sh;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            sh   = bits >> node;
            node = 2 * node + 1 + (sh[0] ? 1 : 0);
        end
        return WAY_W'(node - (WAYS - 1));
    endfunction

    // Point every node on the path to the accessed way at the opposite subtree.
    function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] bits,
                                                   input logic [WAY_W-1:0] way);
        int               node;
        logic [WAY_W-1:0] sh;
        logic [PL_W-1:0]  res;
        node = 0;
        res  = bits;
        for (int l = 0; l < WAY_W; l++) begin
            sh = way >> (WAY_W - 1 - l);
            if (sh[0]) res = res & ~(PL_W'(1) << node);
            else       res = res | (PL_W'(1) << node);
            node = 2 * node + 1 + (sh[0] ? 1 : 0);
        end
        return res;
    endfunction

    assign w_flush_now = (r_state == PASS_THRU) && (flush || r_flush_pend);
    assign w_accept    = ufp_ready && (|ufp_rmask);
    assign w_fill      = (r_state == ALLOCATE) && dfp_resp;

    // Tag compare of the staged request against every way of its set.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_stg_vld && r_valid[r_stg_set][w] && r_tag[r_stg_set][w] == r_stg_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the PLRU choice.
    always_comb begin
        w_vict = plru_victim(r_plru[r_stg_set]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[r_stg_set][w]) w_vict = WAY_W'(w);
        end
    end

    assign w_line_sh = r_data[r_stg_set][w_hit_way] >> (32'(r_stg_widx) * FETCH_W);
    assign ufp_rdata = ufp_resp ? w_line_sh[FETCH_W-1:0] : '0;

    // State register; reset abandons any fill in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= PASS_THRU;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic and all UFP/DFP handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        ufp_ready   = 1'b0;
        ufp_resp    = 1'b0;
        dfp_read    = 1'b0;
        dfp_addr    = '0;
        case (r_state)
            PASS_THRU: begin
                ufp_ready = (!r_stg_vld || w_hit) && !w_flush_now;
                if (r_stg_vld && !w_flush_now) begin
                    if (w_hit) ufp_resp    = 1'b1;
                    else       w_state_nxt = ALLOCATE;
                end
            end
            ALLOCATE: begin
                dfp_read = 1'b1;
                dfp_addr = {r_stg_tag, r_stg_set, OFF_W'(0)};
                if (dfp_resp) w_state_nxt = ALLOCATE_STALL;
            end
            ALLOCATE_STALL: begin
                ufp_resp    = 1'b1;
                ufp_ready   = 1'b1;
                w_state_nxt = PASS_THRU;
            end
            default: w_state_nxt = PASS_THRU;
        endcase
    end

    // Stage occupancy: filled on accept, emptied on response or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_stg_vld <= 1'b0;
        else if (w_flush_now) r_stg_vld <= 1'b0;
        else if (w_accept)    r_stg_vld <= 1'b1;
        else if (ufp_resp)    r_stg_vld <= 1'b0;
    end

    // Stage address fields; only meaningful while r_stg_vld is set.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_stg_widx <= WIDX_W'(ufp_addr[OFF_W-1:0] >> BYTE_W);
            r_stg_set  <= ufp_addr[OFF_W +: SET_W];
            r_stg_tag  <= ufp_addr[ADDR_W-1 -: TAG_W];
        end
    end

    // A flush seen while a fill is outstanding waits for the next PASS_THRU cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_flush_pend <= 1'b0;
        else if (w_flush_now) r_flush_pend <= 1'b0;
        else if (flush)       r_flush_pend <= 1'b1;
    end

    // Valid and PLRU bookkeeping: cleared by flush, updated on hit and on fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_flush_now) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            if (r_state == PASS_THRU && ufp_resp)
                r_plru[r_stg_set] <= plru_touch(r_plru[r_stg_set], w_hit_way);
            if (w_fill) begin
                r_valid[r_stg_set][w_vict] <= 1'b1;
                r_plru[r_stg_set]          <= plru_touch(r_plru[r_stg_set], w_vict);
            end
        end
    end

    // Tag and line storage written by the fill.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[r_stg_set][w_vict]  <= r_stg_tag;
            r_data[r_stg_set][w_vict] <= dfp_rdata;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_perf_hit, r_perf_miss;
    logic        w_hit_evt, w_miss_evt;
    assign w_hit_evt  = (r_state == PASS_THRU) && ufp_resp;
    assign w_miss_evt = (r_state == PASS_THRU) && (w_state_nxt == ALLOCATE);

    // Saturating hit/miss event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_hit  <= '0;
            r_perf_miss <= '0;
        end else begin
            if (w_hit_evt && r_perf_hit != '1)   r_perf_hit  <= r_perf_hit + 32'd1;
            if (w_miss_evt && r_perf_miss != '1) r_perf_miss <= r_perf_miss + 32'd1;
        end
    end
    assign perf_hit_cnt  = r_perf_hit;
    assign perf_miss_cnt = r_perf_miss;
`endif
endmodule

// File: tb/tb_icache_ctrl_nway.sv
// Bench for icache_ctrl_nway: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-level cache model.
module tb_icache_ctrl_nway;
    localparam int ADDR_W = 32, LINE_BYTES = 32, SETS = 16, WAYS = 4, FETCH_W = 32;
    localparam int LINE_W = LINE_BYTES * 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       ufp_addr = '0;
    logic [3:0]        ufp_rmask = '0;
    logic              ufp_ready, ufp_resp, dfp_read;
    logic [31:0]       ufp_rdata, dfp_addr;
    logic              flush = 1'b0;
    logic [LINE_W-1:0] dfp_rdata = '0;
    logic              dfp_resp = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]       perf_hit_cnt, perf_miss_cnt;
`endif

    icache_ctrl_nway #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .SETS(SETS),
                       .WAYS(WAYS), .FETCH_W(FETCH_W)) dut (
        .clk(clk), .rst(rst), .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask),
        .ufp_ready(ufp_ready), .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
        .flush(flush), .dfp_addr(dfp_addr), .dfp_read(dfp_read),
        .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
`ifdef ICACHE_PERF_CNT_EN
        , .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Backing memory contents: a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (wa == 32'h0000_1004) return 32'hDEAD_BEEF;
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    function automatic logic [LINE_W-1:0] line_of(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_BYTES / 4; k++) l[k*32 +: 32] = mem_word(la + 32'(4 * k));
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] junk_line();
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_BYTES / 4; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // Reference model: cache contents with per-way last-use time stamps.
    bit          m_vld  [SETS][WAYS];
    logic [22:0] m_tag  [SETS][WAYS];
    int          m_stamp[SETS][WAYS];
    int          m_time;
    bit          m_req_v, m_busy, m_done, m_defer;
    logic [31:0] m_req_addr;
    int          m_hits, m_misses;
    bit          obs_resp, obs_dread;
    logic [31:0] obs_rdata, obs_daddr;

    function automatic int set_of(input logic [31:0] a);
        return int'(a[8:5]);
    endfunction

    function automatic int m_lookup(input logic [31:0] a);
        int s = set_of(a);
        for (int w = 0; w < WAYS; w++) if (m_vld[s][w] && m_tag[s][w] == a[31:9]) return w;
        return -1;
    endfunction

    // Tree-PLRU viewed by recency: at each split go to the half used less recently.
    function automatic int m_victim(input int s);
        int lo, n, half, ml, mr;
        for (int w = 0; w < WAYS; w++) if (!m_vld[s][w]) return w;
        lo = 0;
        n  = WAYS;
        while (n > 1) begin
            half = n / 2;
            ml = 0;
            mr = 0;
            for (int w = 0; w < half; w++) begin
                if (m_stamp[s][lo + w] > ml)        ml = m_stamp[s][lo + w];
                if (m_stamp[s][lo + half + w] > mr) mr = m_stamp[s][lo + half + w];
            end
            if (mr < ml) lo = lo + half;
            n = half;
        end
        return lo;
    endfunction

    task automatic m_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_vld[s][w]   = 1'b0;
                m_stamp[s][w] = 0;
            end
    endtask

    task automatic m_reset();
        m_clear();
        m_req_v = 0; m_busy = 0; m_done = 0; m_defer = 0;
        m_hits = 0; m_misses = 0; m_time = 0;
    endtask

    // One clock: drive at the falling edge, check settled outputs, advance the model.
    task automatic cyc(input bit rq, input logic [31:0] a, input bit fl, input bit dr);
        bit          idle, feff, e_hit, e_miss, e_ready, e_resp, nd;
        int          hw, v, s;
        logic [31:0] e_rdata, e_daddr;
        @(negedge clk);
        ufp_rmask = rq ? 4'($urandom_range(1, 15)) : 4'h0;
        ufp_addr  = a;
        flush     = fl;
        dfp_resp  = dr;
        dfp_rdata = m_busy ? line_of(line_addr(m_req_addr)) : junk_line();
        #1;
        idle    = !m_busy && !m_done;
        feff    = idle && (fl || m_defer);
        hw      = m_req_v ? m_lookup(m_req_addr) : -1;
        e_hit   = idle && !feff && m_req_v && hw >= 0;
        e_miss  = idle && !feff && m_req_v && hw < 0;
        e_ready = m_done || (idle && !feff && (!m_req_v || hw >= 0));
        e_resp  = m_done || e_hit;
        e_rdata = e_resp ? mem_word(m_req_addr) : 32'h0;
        e_daddr = m_busy ? line_addr(m_req_addr) : 32'h0;
        chk("ufp_ready", 64'(ufp_ready), 64'(e_ready));
        chk("ufp_resp", 64'(ufp_resp), 64'(e_resp));
        chk("ufp_rdata", 64'(ufp_rdata), 64'(e_rdata));
        chk("dfp_read", 64'(dfp_read), 64'(m_busy));
        chk("dfp_addr", 64'(dfp_addr), 64'(e_daddr));
        obs_resp  = ufp_resp;
        obs_dread = dfp_read;
        obs_rdata = ufp_rdata;
        obs_daddr = dfp_addr;
        if (feff) begin
            m_clear();
            m_defer = 0;
        end else if (fl && !idle) m_defer = 1;
        if (e_hit) begin
            m_time++;
            m_stamp[set_of(m_req_addr)][hw] = m_time;
            m_hits++;
        end
        nd = m_busy && dr;
        if (nd) begin
            s = set_of(m_req_addr);
            v = m_victim(s);
            m_vld[s][v] = 1'b1;
            m_tag[s][v] = m_req_addr[31:9];
            m_time++;
            m_stamp[s][v] = m_time;
            m_busy = 0;
        end
        if (e_miss) begin
            m_busy = 1;
            m_misses++;
        end
        m_done = nd;
        if (e_ready && rq) begin
            m_req_v    = 1;
            m_req_addr = a;
        end else if (e_resp || feff) m_req_v = 0;
    endtask

    // Issue one fetch and run until its response; memory answers after lat busy cycles.
    task automatic fetch(input logic [31:0] a, input int lat, output bit missed, output int ncyc,
                         output logic [31:0] daddr);
        int n;
        bit done, dr;
        n = 0; done = 0; missed = 0; ncyc = 0; daddr = '0;
        cyc(1, a, 0, 0);
        for (int i = 0; i < 40 && !done; i++) begin
            dr = m_busy && (n >= lat);
            if (m_busy) n++;
            cyc(0, 32'h0, 0, dr);
            ncyc++;
            if (obs_dread) begin
                missed = 1;
                daddr  = obs_daddr;
            end
            if (obs_resp) done = 1;
        end
        if (!done) chk("fetch_timeout", 64'(done), 64'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        ufp_rmask = 0; flush = 0; dfp_resp = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_dfp_read", 64'(dfp_read), 64'(0));
        chk("arst_ready", 64'(ufp_ready), 64'(1));
        chk("arst_resp", 64'(ufp_resp), 64'(0));
        m_reset();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        bit          missed, e_miss;
        int          ncyc, cnt, rdy;
        logic [31:0] da, a;
        bit          fl, dr, rq;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(ufp_ready), 64'(1));
        chk("rst_resp", 64'(ufp_resp), 64'(0));
        chk("rst_rdata", 64'(ufp_rdata), 64'(0));
        chk("rst_dfp_read", 64'(dfp_read), 64'(0));
        chk("rst_dfp_addr", 64'(dfp_addr), 64'(0));
        #2 rst = 1'b0;

        // Cold miss followed by a hit to the same word.
        fetch(32'h0000_1004, 3, missed, ncyc, da);
        chk("cold_missed", 64'(missed), 64'(1));
        chk("cold_dfp_addr", 64'(da), 64'h1000);
        chk("cold_rdata", 64'(obs_rdata), 64'hDEAD_BEEF);
        fetch(32'h0000_1004, 0, missed, ncyc, da);
        chk("refetch_missed", 64'(missed), 64'(0));
        chk("refetch_latency", 64'(ncyc), 64'(1));
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_miss_cnt", 64'(perf_miss_cnt), 64'(1));
        chk("perf_hit_cnt", 64'(perf_hit_cnt), 64'(1));
`endif

        // Eight back-to-back hits across the filled line.
        cnt = 0;
        rdy = 0;
        for (int k = 0; k < 9; k++) begin
            cyc(k < 8, 32'h0000_1000 + 32'(4 * k), 0, 0);
            if (obs_resp) cnt++;
            if (k < 8 && ufp_ready) rdy++;
        end
        chk("stream_resp_cnt", 64'(cnt), 64'(8));
        chk("stream_ready_cnt", 64'(rdy), 64'(8));

        // Replacement in set 0.
        do_reset();
        fetch(32'h0000_0000, 1, missed, ncyc, da);
        fetch(32'h0000_0200, 1, missed, ncyc, da);
        fetch(32'h0000_0400, 1, missed, ncyc, da);
        fetch(32'h0000_0600, 1, missed, ncyc, da);
        fetch(32'h0000_0000, 1, missed, ncyc, da);
        chk("repl_hit0", 64'(missed), 64'(0));
        fetch(32'h0000_0800, 1, missed, ncyc, da);
        chk("repl_new_miss", 64'(missed), 64'(1));
        fetch(32'h0000_0000, 1, missed, ncyc, da);
        chk("repl_keep0", 64'(missed), 64'(0));
        e_miss = m_lookup(32'h0000_0400) < 0;
        fetch(32'h0000_0400, 1, missed, ncyc, da);
        chk("repl_0400", 64'(missed), 64'(e_miss));

        // Flush during a fill: response still delivered, line gone afterwards.
        cyc(1, 32'h0000_2000, 0, 0);
        cyc(0, 32'h0, 0, 0);
        cyc(0, 32'h0, 1, 0);
        cyc(0, 32'h0, 0, 1);
        cyc(0, 32'h0, 0, 0);
        chk("flush_alloc_resp", 64'(obs_resp), 64'(1));
        cyc(0, 32'h0, 0, 0);
        fetch(32'h0000_2000, 0, missed, ncyc, da);
        chk("flush_alloc_refetch", 64'(missed), 64'(1));

        // Async reset mid-fill, then a stray fill response.
        cyc(1, 32'h0000_3000, 0, 0);
        cyc(0, 32'h0, 0, 0);
        cyc(0, 32'h0, 0, 0);
        chk("pre_arst_read", 64'(obs_dread), 64'(1));
        do_reset();
        cyc(0, 32'h0, 0, 1);
        chk("stray_resp", 64'(obs_resp), 64'(0));
        fetch(32'h0000_3000, 2, missed, ncyc, da);
        chk("arst_refetch", 64'(missed), 64'(1));

        // Random traffic over a few conflicting lines.
        for (int i = 0; i < 3000; i++) begin
            a  = (32'($urandom_range(0, 5)) << 9) | (32'($urandom_range(0, 1)) << 5) |
                 (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            rq = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 39) == 0);
            dr = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            cyc(rq, a, fl, dr);
        end
`ifdef ICACHE_PERF_CNT_EN
        #1;
        chk("perf_hit_total", 64'(perf_hit_cnt), 64'(m_hits));
        chk("perf_miss_total", 64'(perf_miss_cnt), 64'(m_misses));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
